axilite_user_arbiter: RTL and testbench
=======================================

Name: axilite_user_arbiter

Overview:
- Shares one AXI-Lite master user command port among NREQ requesters (e.g. CPU bridge, DMA config, debug).
- Uses round-robin arbitration and keeps exactly one transaction outstanding.
- Captures the master's command and returns the response (read data and status) only to the requester that issued it.
- Sits directly in front of the master's user_* ports.

Parameters:
- NREQ, 4, number of requesters (2..8)
- ADDR_W, 32, address width
- DATA_W, 64, data width; strobe width is DATA_W/8
- IDW, 2, width of grant index; must equal clog2(NREQ)

Ports:
- aclk  in  1  clock
- aresetn  in  1  async active-low reset
- req_valid  in  NREQ  per-requester command valid
- req_ready  out  NREQ  per-requester command accept (one-hot, at most one bit high)
- req_w_r  in  NREQ  0=write, 1=read, one bit per requester
- req_addr  in  NREQ*ADDR_W  packed addresses; requester i at [i*ADDR_W +: ADDR_W]
- req_wdata  in  NREQ*DATA_W  packed write data
- req_strb  in  NREQ*DATA_W/8  packed write strobes
- rsp_valid  out  NREQ  one-cycle response pulse to the owning requester
- rsp_rdata  out  DATA_W  shared response data; valid only with rsp_valid
- rsp_status  out  2  shared response code (AXI resp encoding)
- busy  out  1  transaction in flight
- grant_id  out  IDW  index of current or most recent owner
- m_start  out  1  command strobe to master
- m_w_r  out  1  command direction
- m_addr  out  ADDR_W  command address
- m_wdata  out  DATA_W  command write data
- m_strb  out  DATA_W/8  command strobe
- m_free  in  1  master can accept a command
- m_status  in  2  master response status
- m_rdata  in  DATA_W  master read data
- m_resp_valid  in  1  master response valid; level, sticky until the master's next address phase

Behaviour:
- Reset values: all outputs 0; round-robin pointer last_grant = NREQ-1, so requester 0 has priority first.
- FSM states: IDLE, ISSUE, WAIT_CLR, WAIT_RESP, RESP.
- IDLE:
  - When any req_valid is set and m_free=1, select the first requester at or after (last_grant+1) mod NREQ with req_valid high.
  - Assert that requester's req_ready combinationally in the same cycle. This is the accept handshake.
  - On the clock edge, register w_r/addr/wdata/strb into the m_* outputs, set grant_id and last_grant, go to ISSUE.
  - If m_free=0, req_ready stays 0 and the FSM stays in IDLE.
- ISSUE: m_start=1 for exactly this one cycle, m_* stable; go to WAIT_CLR.
- WAIT_CLR: m_resp_valid may still be high from the previous transaction.
  - Stay until m_resp_valid=0, then go to WAIT_RESP.
  - m_* hold their values until RESP.
- WAIT_RESP: on the cycle m_resp_valid=1, capture m_rdata into rsp_rdata and m_status into rsp_status; go to RESP.
- RESP:
  - rsp_valid[grant_id]=1 for one cycle; go to IDLE.
  - rsp_rdata is 0 for writes (forced at capture).
  - rsp_rdata and rsp_status hold their values until the next capture.
- busy=1 in ISSUE, WAIT_CLR, WAIT_RESP and RESP; 0 in IDLE.
- Latency:
  - Best case, request accept to rsp_valid is 4 cycles plus master latency.
  - Next grant can occur in the cycle after RESP.
- Fairness: a requester holding req_valid high is granted within NREQ transactions.
  - Requests that drop req_valid before being accepted are simply not granted; no error.
- Simultaneous requests from all requesters: strict rotation 0,1,2,3,0,...
- req_valid asserted in RESP: not accepted until IDLE.
- Requester inputs are sampled only on the accept cycle; later changes are ignored.
- Error responses (status 2'b10/2'b11) are passed through unchanged. The arbiter does not retry.
- Reset mid-operation:
  - FSM returns to IDLE, all outputs go to 0, last_grant = NREQ-1.
  - Any pending response is dropped.
  - The master is reset on the same aresetn.

Test Plan:
- Single write from requester 2 (addr 0x40, data 0xDEADBEEF, strb 0xFF), slave bresp=00: req_ready[2] pulses once, m_start pulses once with m_addr=0x40, rsp_valid[2] pulses, rsp_status=00, rsp_rdata=0.
- All four requesters hold reads to addresses 0x0/0x4/0x8/0xC: grants in order 0,1,2,3,0.
  - Each rsp_valid[i] pulses only for its owner, with rdata matching the slave model per address.
- Back-to-back transactions with sticky m_resp_valid still high from the previous one: FSM waits in WAIT_CLR.
  - No early rsp_valid; the second response carries the second read's data (0x1234).
- Slave returns rresp=2'b10 on read from requester 1: rsp_status=10 delivered to requester 1 only; the next arbitration proceeds normally.
- Hold m_free=0 for 10 cycles with req_valid[3]=1: req_ready stays 0 and m_start stays 0; accepted in the cycle m_free rises.
- Assert aresetn=0 during WAIT_RESP: all outputs go to 0 immediately.
  - After release, a request from requester 3 alongside requester 0 grants requester 0 first.

Source files
------------

// File: rtl/axilite_user_arbiter.sv
// Round-robin arbiter sharing one AXI-Lite master user command port among NREQ requesters.
// One transaction in flight; the response is routed back only to the requester that issued it.
module axilite_user_arbiter #(
  parameter int unsigned NREQ   = 4,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned IDW    = 2
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ-1:0]          req_w_r,
  input  logic [NREQ*ADDR_W-1:0]   req_addr,
  input  logic [NREQ*DATA_W-1:0]   req_wdata,
  input  logic [NREQ*DATA_W/8-1:0] req_strb,
  output logic [NREQ-1:0]          rsp_valid,
  output logic [DATA_W-1:0]        rsp_rdata,
  output logic [1:0]               rsp_status,
  output logic                     busy,
  output logic [IDW-1:0]           grant_id,
  output logic                     m_start,
  output logic                     m_w_r,
  output logic [ADDR_W-1:0]        m_addr,
  output logic [DATA_W-1:0]        m_wdata,
  output logic [DATA_W/8-1:0]      m_strb,
  input  logic                     m_free,
  input  logic [1:0]               m_status,
  input  logic [DATA_W-1:0]        m_rdata,
  input  logic                     m_resp_valid
);

  localparam int unsigned STRB_W = DATA_W / 8;

  typedef enum logic [2:0] {StIdle, StIssue, StWaitClr, StWaitResp, StResp} state_e;

  state_e         state_q, state_d;
  logic [IDW-1:0] last_grant_q;
  logic [IDW-1:0] sel_idx;
  logic           sel_found;
  logic           accept;

  // Search starts one past the previous owner so every waiting requester gets its turn.
  always_comb begin
    int unsigned    j;
    logic [IDW-1:0] cand;
    sel_idx   = '0;
    sel_found = 1'b0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      j    = (32'(last_grant_q) + k) % NREQ;
      cand = IDW'(j);
      if (!sel_found && req_valid[cand]) begin
        sel_idx   = cand;
        sel_found = 1'b1;
      end
    end
  end

  assign accept = (state_q == StIdle) && m_free && sel_found;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:     if (accept) state_d = StIssue;
      StIssue:    state_d = StWaitClr;
      // The previous response may still be held high by the master.
      StWaitClr:  if (!m_resp_valid) state_d = StWaitResp;
      StWaitResp: if (m_resp_valid) state_d = StResp;
      StResp:     state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    if (accept && aresetn) req_ready[sel_idx] = 1'b1;
    if (state_q == StResp) rsp_valid[grant_id] = 1'b1;
    busy    = (state_q != StIdle);
    m_start = (state_q == StIssue);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      last_grant_q <= IDW'(NREQ - 1);
      grant_id     <= '0;
      m_w_r        <= 1'b0;
      m_addr       <= '0;
      m_wdata      <= '0;
      m_strb       <= '0;
      rsp_rdata    <= '0;
      rsp_status   <= '0;
    end else begin
      if (accept) begin
        last_grant_q <= sel_idx;
        grant_id     <= sel_idx;
        m_w_r        <= req_w_r[sel_idx];
        m_addr       <= req_addr[sel_idx*ADDR_W +: ADDR_W];
        m_wdata      <= req_wdata[sel_idx*DATA_W +: DATA_W];
        m_strb       <= req_strb[sel_idx*STRB_W +: STRB_W];
      end
      if (state_q == StWaitResp && m_resp_valid) begin
        rsp_rdata  <= m_w_r ? m_rdata : '0;
        rsp_status <= m_status;
      end
    end
  end

endmodule

// File: tb/tb_axilite_user_arbiter.sv
// Scoreboard bench: a behavioural arbitration/slave model predicts grants, commands and responses;
// a negedge monitor compares the DUT against the queued expectations.
module tb_axilite_user_arbiter;

  localparam int NREQ   = 4;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 64;
  localparam int IDW    = 2;
  localparam int STRB_W = DATA_W / 8;

  logic                   aclk = 1'b0;
  logic                   aresetn = 1'b0;
  logic [NREQ-1:0]        req_valid = '0;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ-1:0]        req_w_r = '0;
  logic [NREQ*ADDR_W-1:0] req_addr = '0;
  logic [NREQ*DATA_W-1:0] req_wdata = '0;
  logic [NREQ*STRB_W-1:0] req_strb = '0;
  logic [NREQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]      rsp_rdata;
  logic [1:0]             rsp_status;
  logic                   busy;
  logic [IDW-1:0]         grant_id;
  logic                   m_start;
  logic                   m_w_r;
  logic [ADDR_W-1:0]      m_addr;
  logic [DATA_W-1:0]      m_wdata;
  logic [STRB_W-1:0]      m_strb;
  logic                   m_free = 1'b1;
  logic [1:0]             m_status = '0;
  logic [DATA_W-1:0]      m_rdata = '0;
  logic                   m_resp_valid = 1'b0;

  always #5 aclk = ~aclk;

  axilite_user_arbiter #(
    .NREQ  (NREQ),
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .IDW   (IDW)
  ) dut (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_w_r     (req_w_r),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .req_strb    (req_strb),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .rsp_status  (rsp_status),
    .busy        (busy),
    .grant_id    (grant_id),
    .m_start     (m_start),
    .m_w_r       (m_w_r),
    .m_addr      (m_addr),
    .m_wdata     (m_wdata),
    .m_strb      (m_strb),
    .m_free      (m_free),
    .m_status    (m_status),
    .m_rdata     (m_rdata),
    .m_resp_valid(m_resp_valid)
  );

  typedef struct {
    logic              w_r;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] strb;
  } cmd_t;

  typedef struct {
    int                owner;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        status;
  } rsp_t;

  int n_cmp = 0;
  int n_err = 0;

  cmd_t              cmd_q[$];
  rsp_t              rsp_q[$];
  int                owner_log[$];
  int                last_gr = NREQ - 1;
  bit                outst = 1'b0;
  bit                start_due = 1'b0;
  bit                fresh = 1'b0;
  int                wait_cnt = 0;
  logic [DATA_W-1:0] last_rdata = '0;
  logic [1:0]        last_status = '0;
  logic [NREQ-1:0]   accepted = '0;
  int                fix_clr = -1;
  int                fix_lat = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Slave behaviour: read data and status are fixed functions of the address.
  function automatic logic [DATA_W-1:0] slave_rdata(input logic [ADDR_W-1:0] a);
    return {a, 32'h0} ^ 64'h1234;
  endfunction

  function automatic logic [1:0] slave_status(input logic [ADDR_W-1:0] a);
    return a[29:28];
  endfunction

  function automatic int pick(input logic [NREQ-1:0] v, input int last);
    for (int k = 1; k <= NREQ; k++) begin
      if (v[(last + k) % NREQ]) return (last + k) % NREQ;
    end
    return -1;
  endfunction

  // Master/slave model: sticky response valid, cleared fix_clr/random cycles after m_start.
  initial begin
    int                clr;
    int                lat;
    bit                pend;
    logic              st;
    logic              swr;
    logic              wr;
    logic [ADDR_W-1:0] sa;
    logic [ADDR_W-1:0] a;
    pend = 1'b0;
    clr  = 0;
    lat  = 1;
    wr   = 1'b0;
    a    = '0;
    forever begin
      @(negedge aclk);
      st  = m_start;
      sa  = m_addr;
      swr = m_w_r;
      @(posedge aclk);
      #1;
      if (!aresetn) begin
        m_resp_valid = 1'b0;
        pend         = 1'b0;
        fresh        = 1'b0;
      end else begin
        if (st) begin
          pend  = 1'b1;
          a     = sa;
          wr    = swr;
          clr   = (fix_clr >= 0) ? fix_clr : int'($urandom_range(0, 3));
          lat   = (fix_lat > 0) ? fix_lat : int'($urandom_range(1, 4));
          fresh = 1'b0;
        end else if (pend) begin
          if (clr > 0) clr--;
          else if (lat > 1) lat--;
          else begin
            m_resp_valid = 1'b1;
            m_status     = slave_status(a);
            m_rdata      = wr ? slave_rdata(a) : {$urandom(), $urandom()};
            fresh        = 1'b1;
            pend         = 1'b0;
          end
        end
        if (pend && clr == 0) m_resp_valid = 1'b0;
      end
    end
  end

  // Monitor and scoreboard.
  initial begin
    forever begin
      @(negedge aclk);
      if (aresetn) begin : mon
        logic [NREQ-1:0] exp_rdy;
        logic [NREQ-1:0] exp_v;
        int              p;
        cmd_t            c;
        rsp_t            r;
        exp_rdy = '0;
        p       = -1;
        if (!outst && m_free) p = pick(req_valid, last_gr);
        if (p >= 0) exp_rdy[p] = 1'b1;
        chk("req_ready", req_ready, exp_rdy);
        chk("busy", busy, outst);
        chk("m_start", m_start, start_due);
        if (m_start) begin
          if (cmd_q.size() == 0) begin
            chk("m_start_unexpected", m_start, 0);
          end else begin
            c = cmd_q.pop_front();
            chk("m_w_r", m_w_r, c.w_r);
            chk("m_addr", m_addr, c.addr);
            chk("m_wdata", m_wdata, c.wdata);
            chk("m_strb", m_strb, c.strb);
          end
        end
        if (rsp_valid != '0) begin
          if (rsp_q.size() == 0) begin
            chk("rsp_unexpected", rsp_valid, 0);
          end else begin
            r = rsp_q.pop_front();
            exp_v = '0;
            exp_v[r.owner] = 1'b1;
            chk("rsp_valid", rsp_valid, exp_v);
            chk("rsp_rdata", rsp_rdata, r.rdata);
            chk("rsp_status", rsp_status, r.status);
            chk("grant_id", grant_id, r.owner);
            chk("rsp_after_fresh_resp", fresh, 1);
            owner_log.push_back(r.owner);
            last_rdata  = rsp_rdata;
            last_status = rsp_status;
          end
          fresh = 1'b0;
          outst = 1'b0;
        end else if (outst) begin
          wait_cnt++;
          if (wait_cnt > 200) begin
            chk("rsp_timeout", rsp_valid, 1);
            outst = 1'b0;
            rsp_q.delete();
          end
        end
        start_due = 1'b0;
        accepted  = req_ready;
        if (p >= 0) begin
          c.w_r   = req_w_r[p];
          c.addr  = req_addr[p*ADDR_W +: ADDR_W];
          c.wdata = req_wdata[p*DATA_W +: DATA_W];
          c.strb  = req_strb[p*STRB_W +: STRB_W];
          cmd_q.push_back(c);
          r.owner  = p;
          r.rdata  = c.w_r ? slave_rdata(c.addr) : '0;
          r.status = slave_status(c.addr);
          rsp_q.push_back(r);
          outst     = 1'b1;
          start_due = 1'b1;
          last_gr   = p;
          wait_cnt  = 0;
        end
      end
    end
  end

  // Accepted requesters drop valid and scramble their fields, which the DUT must ignore.
  task automatic tick();
    @(posedge aclk);
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (accepted[i]) begin
        req_valid[i] = 1'b0;
        req_addr[i*ADDR_W +: ADDR_W] = $urandom();
        req_wdata[i*DATA_W +: DATA_W] = {$urandom(), $urandom()};
        req_w_r[i] = ~req_w_r[i];
      end
    end
    accepted = '0;
  endtask

  task automatic send(input int i, input logic wr, input logic [ADDR_W-1:0] a,
                      input logic [DATA_W-1:0] d, input logic [STRB_W-1:0] s);
    req_w_r[i] = wr;
    req_addr[i*ADDR_W +: ADDR_W] = a;
    req_wdata[i*DATA_W +: DATA_W] = d;
    req_strb[i*STRB_W +: STRB_W] = s;
    req_valid[i] = 1'b1;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((req_valid != '0 || outst || busy) && n < 400) begin
      tick();
      n++;
    end
    chk(name, n < 400, 1);
  endtask

  task automatic wait_accept(input int i);
    int n;
    n = 0;
    while (req_valid[i] && n < 100) begin
      tick();
      n++;
    end
    chk("accept_wait", n < 100, 1);
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    #1;
    chk("rst_ctrl", {req_ready, rsp_valid, busy, grant_id, m_start, m_w_r}, 0);
    chk("rst_m_addr", m_addr, 0);
    chk("rst_m_wdata", m_wdata, 0);
    chk("rst_m_strb", m_strb, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rsp_status", rsp_status, 0);
    req_valid = '0;
    accepted  = '0;
    cmd_q.delete();
    rsp_q.delete();
    outst     = 1'b0;
    start_due = 1'b0;
    fresh     = 1'b0;
    last_gr   = NREQ - 1;
    wait_cnt  = 0;
    repeat (2) @(posedge aclk);
    #1;
    aresetn = 1'b1;
  endtask

  initial begin
    // Reset with all requests raised and master free: outputs must still be zero.
    req_valid = '1;
    m_free    = 1'b1;
    repeat (3) @(posedge aclk);
    #1;
    do_reset();
    tick();

    // Single write from requester 2.
    owner_log.delete();
    send(2, 1'b0, 32'h40, 64'hDEAD_BEEF, 8'hFF);
    wait_idle("write_done");
    chk("write_owner", owner_log.size() == 1 ? owner_log[0] : -1, 2);
    chk("write_rdata", last_rdata, 0);
    chk("write_status", last_status, 0);

    // All four read at once after reset: rotation 0,1,2,3,0.
    do_reset();
    owner_log.delete();
    for (int i = 0; i < NREQ; i++) send(i, 1'b1, ADDR_W'(4 * i), '0, '0);
    wait_accept(0);
    send(0, 1'b1, 32'h0, '0, '0);
    wait_idle("rotate_done");
    chk("rotate_count", owner_log.size(), 5);
    for (int i = 0; i < 5; i++) begin
      chk("rotate_order", owner_log.size() > i ? owner_log[i] : -1, i % NREQ);
    end

    // Back-to-back with the previous response still held high.
    fix_clr = 3;
    send(1, 1'b1, 32'h10, '0, '0);
    wait_accept(1);
    send(1, 1'b1, 32'h0, '0, '0);
    wait_idle("sticky_done");
    chk("sticky_rdata", last_rdata, 64'h1234);
    fix_clr = -1;

    // Error status passes through to requester 1 only; next arbitration is normal.
    owner_log.delete();
    send(1, 1'b1, 32'h2000_0000, '0, '0);
    wait_idle("err_done");
    chk("err_status", last_status, 2'b10);
    chk("err_owner", owner_log.size() == 1 ? owner_log[0] : -1, 1);
    send(2, 1'b1, 32'h8, '0, '0);
    wait_idle("after_err_done");
    chk("after_err_owner", owner_log.size() == 2 ? owner_log[1] : -1, 2);
    chk("after_err_status", last_status, 2'b00);

    // Master not free: no accept until m_free rises.
    m_free = 1'b0;
    send(3, 1'b0, 32'h100, 64'h55, 8'h0F);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("hold_ready", req_ready, 0);
      chk("hold_start", m_start, 0);
    end
    m_free = 1'b1;
    #1;
    chk("free_ready", req_ready, 4'b1000);
    wait_idle("free_done");

    // Reset while waiting for the response.
    fix_clr = 0;
    fix_lat = 30;
    send(1, 1'b1, 32'h20, '0, '0);
    begin
      int n;
      n = 0;
      while (!m_start && n < 20) begin
        tick();
        n++;
      end
      chk("rst_mid_start_seen", m_start, 1);
    end
    repeat (3) tick();
    chk("rst_mid_busy", busy, 1);
    do_reset();
    fix_clr = -1;
    fix_lat = 0;
    owner_log.delete();
    send(3, 1'b1, 32'h30, '0, '0);
    send(0, 1'b1, 32'h34, '0, '0);
    wait_idle("rst_mid_done");
    chk("rst_mid_count", owner_log.size(), 2);
    chk("rst_mid_first", owner_log.size() > 0 ? owner_log[0] : -1, 0);
    chk("rst_mid_second", owner_log.size() > 1 ? owner_log[1] : -1, 3);

    // Randomised traffic with occasional master stalls and abandoned requests.
    for (int c = 0; c < 3000; c++) begin
      tick();
      m_free = ($urandom_range(0, 9) != 0);
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i]) begin
          if ($urandom_range(0, 3) == 0) begin
            send(i, 1'($urandom()), $urandom(), {$urandom(), $urandom()}, 8'($urandom()));
          end
        end else if ($urandom_range(0, 39) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
    end
    m_free = 1'b1;
    wait_idle("random_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
